// File: rtl/axis2router_pkg.sv
// Shared types and flit layout helpers for the AXI-Stream to router packetiser.
// The framing field is the two MSBs of a flit; HEAD_BIT/TAIL_BIT index into it.
package axis2router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam int HEAD_BIT = 1;
   localparam int TAIL_BIT = 0;

   function automatic int flit_w(input int data_w);
      return data_w + data_w / 8 + 2;
   endfunction

endpackage

// File: rtl/axis2router_pkt_if.sv
// AXI-Stream beat channel feeding the packetiser.
interface axis2router_pkt_if #(
   parameter int DATA_W = 64,
   parameter int KEEP_W = DATA_W / 8
);
   logic [DATA_W-1:0] s_tdata;
   logic [KEEP_W-1:0] s_tkeep;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;

   modport master (output s_tdata, s_tkeep, s_tvalid, s_tlast, input s_tready);
   modport slave  (input s_tdata, s_tkeep, s_tvalid, s_tlast, output s_tready);
endinterface

// File: rtl/axis2router_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the oldest entry.
// Push when full and pop when empty are ignored.
module stream_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/axis2router_pkt.sv
// AXI-Stream to router packetiser: buffers beats in a FWFT FIFO and emits head/tail
// framed flits over val/ack, truncating packets longer than MAX_FLITS.
module axis2router_pkt
   import axis2router_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int KEEP_W     = DATA_W / 8,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_FLITS  = 256,
   parameter int STORE_FWD  = 0,
   localparam int FLIT_W    = DATA_W + KEEP_W + 2
) (
   input  logic                clk,
   input  logic                rst,
   axis2router_pkt_if.slave    axis,
   output logic [FLIT_W-1:0]   data_router,
   output logic                val,
   input  logic                ack,
   output logic [15:0]         oversize_cnt
);
   localparam int PW  = DATA_W + KEEP_W;
   localparam int EW  = PW + 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int FCW = $clog2(MAX_FLITS + 1);

   state_t           state, state_nxt;
   logic [EW-1:0]    head_q;
   logic             full, empty, push, pop, xfer;
   logic [CW-1:0]    fifo_cnt, pkt_cnt;
   logic [FCW-1:0]   flit_cnt;
   logic             head, tail, forced, is_last, avail;
   logic [1:0]       frame;

   assign axis.s_tready = !full && !rst;
   assign push          = axis.s_tvalid && axis.s_tready;

   stream_fifo_fwft #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({axis.s_tlast, axis.s_tdata, axis.s_tkeep}),
      .pop   (pop),
      .dout  (head_q),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt)
   );

   assign is_last = head_q[EW-1];
   assign forced  = (flit_cnt == FCW'(MAX_FLITS - 1));
   assign tail    = is_last || forced;
   // A packet bigger than the FIFO never gets its tlast stored; a full FIFO releases it
   assign avail   = !empty && (STORE_FWD == 0 || pkt_cnt != '0 || fifo_cnt == CW'(FIFO_DEPTH));

   always_comb begin
      state_nxt = state;
      val       = 1'b0;
      head      = 1'b0;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            val  = avail;
            head = 1'b1;
         end
         ST_SEND: val = !empty;
         ST_DROP: pop = !empty;
         default: state_nxt = ST_IDLE;
      endcase
      xfer = val && ack;
      if (xfer) begin
         pop = 1'b1;
         if (is_last)     state_nxt = ST_IDLE;
         else if (forced) state_nxt = ST_DROP;
         else             state_nxt = ST_SEND;
      end else if (state == ST_DROP && pop && is_last) begin
         state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      frame           = '0;
      frame[HEAD_BIT] = head;
      frame[TAIL_BIT] = tail;
      data_router     = val ? {frame, head_q[PW-1:0]} : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         pkt_cnt      <= '0;
         flit_cnt     <= '0;
         oversize_cnt <= '0;
      end else begin
         state <= state_nxt;
         case ({push && axis.s_tlast, pop && is_last})
            2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
            default: ;
         endcase
         // flit_cnt only counts inside a multi-flit packet; IDLE and DROP hold it at zero
         flit_cnt <= (state_nxt == ST_SEND) ? flit_cnt + FCW'(xfer) : '0;
         if (xfer && forced && !is_last && oversize_cnt != 16'hFFFF)
            oversize_cnt <= oversize_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_axis2router_pkt.sv
// Directed bench: cut-through, store-and-forward and truncating instances share one
// stimulus driver; sel picks which instance sees tvalid and is observed.
module tb_axis2router_pkt;
   import axis2router_pkg::*;

   localparam int DW = 32;
   localparam int FW = flit_w(DW);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int            sel = 0;
   logic          tv = 1'b0, tl = 1'b0, ak = 1'b0;
   logic [DW-1:0] td = '0;
   logic [3:0]    tk = '0;

   axis2router_pkt_if #(.DATA_W(DW)) if_ct ();
   axis2router_pkt_if #(.DATA_W(DW)) if_sf ();
   axis2router_pkt_if #(.DATA_W(DW)) if_mf ();

   assign if_ct.s_tdata = td;  assign if_ct.s_tkeep = tk;  assign if_ct.s_tlast = tl;
   assign if_sf.s_tdata = td;  assign if_sf.s_tkeep = tk;  assign if_sf.s_tlast = tl;
   assign if_mf.s_tdata = td;  assign if_mf.s_tkeep = tk;  assign if_mf.s_tlast = tl;
   assign if_ct.s_tvalid = tv && (sel == 0);
   assign if_sf.s_tvalid = tv && (sel == 1);
   assign if_mf.s_tvalid = tv && (sel == 2);

   logic [FW-1:0] dr [3];
   logic          vl [3];
   logic [15:0]   ov [3];

   axis2router_pkt #(.DATA_W(DW), .FIFO_DEPTH(16), .MAX_FLITS(256), .STORE_FWD(0)) u_ct (
      .clk(clk), .rst(rst), .axis(if_ct), .data_router(dr[0]), .val(vl[0]), .ack(ak),
      .oversize_cnt(ov[0]));
   axis2router_pkt #(.DATA_W(DW), .FIFO_DEPTH(16), .MAX_FLITS(256), .STORE_FWD(1)) u_sf (
      .clk(clk), .rst(rst), .axis(if_sf), .data_router(dr[1]), .val(vl[1]), .ack(ak),
      .oversize_cnt(ov[1]));
   axis2router_pkt #(.DATA_W(DW), .FIFO_DEPTH(16), .MAX_FLITS(4), .STORE_FWD(0)) u_mf (
      .clk(clk), .rst(rst), .axis(if_mf), .data_router(dr[2]), .val(vl[2]), .ack(ak),
      .oversize_cnt(ov[2]));

   logic [FW-1:0] cur_data;
   logic          cur_val, cur_tready;
   logic [15:0]   cur_ovs;
   always_comb begin
      cur_data = dr[0]; cur_val = vl[0]; cur_ovs = ov[0]; cur_tready = if_ct.s_tready;
      if (sel == 1) begin
         cur_data = dr[1]; cur_val = vl[1]; cur_ovs = ov[1]; cur_tready = if_sf.s_tready;
      end else if (sel == 2) begin
         cur_data = dr[2]; cur_val = vl[2]; cur_ovs = ov[2]; cur_tready = if_mf.s_tready;
      end
   end

   int tests = 0, fails = 0;
   int first_acc, last_acc, first_val, first_xfer, last_xfer, first_full, stab_err, beats;
   logic [FW-1:0] got [$];
   logic [FW-1:0] expq [$];

   function automatic logic [DW-1:0] dgen(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0001_0203;
   endfunction
   function automatic logic [3:0] kgen(input int i);
      return 4'(i * 5 + 3);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected flits of one packet of n beats whose first beat index is b
   task automatic exp_pkt(input int n, input int b, input int maxf);
      for (int j = 0; j < n && j < maxf; j++)
         expq.push_back({1'(j == 0), 1'((j == n - 1) || (j == maxf - 1)), dgen(b + j), kgen(b + j)});
   endtask

   task automatic cmp_flits(input string tag);
      check({tag, "_nflits"}, 64'(got.size()), 64'(expq.size()));
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         check($sformatf("%s_f%0d", tag, i), 64'(got[i]), 64'(expq[i]));
      expq.delete();
   endtask

   // Drive packets of n1 then n2 beats for exactly maxcyc cycles, collecting flits.
   // Entered and left at posedge+1.
   task automatic run(input int n1, input int n2, input int base, input int ack_off_start,
                      input int ack_off_len, input int gap, input int maxcyc);
      int            bi, n;
      logic          holding;
      logic [FW-1:0] held;
      n = n1 + n2; bi = 0; holding = 1'b0; held = '0;
      got.delete();
      first_acc = -1; last_acc = -1; first_val = -1; first_xfer = -1; last_xfer = -1;
      first_full = -1; stab_err = 0;
      for (int c = 0; c < maxcyc; c++) begin
         tv = (bi < n) && (c % (gap + 1) == 0);
         td = dgen(base + bi);
         tk = kgen(base + bi);
         tl = (bi == n1 - 1) || (bi == n - 1);
         ak = !(c >= ack_off_start && c < ack_off_start + ack_off_len);
         #1;
         if (holding && cur_data !== held) stab_err++;
         if (cur_val && first_val < 0) first_val = c;
         if (!cur_tready && first_full < 0) first_full = c;
         if (tv && cur_tready) begin
            if (first_acc < 0) first_acc = c;
            last_acc = c;
            bi++;
         end
         if (cur_val && ak) begin
            got.push_back(cur_data);
            if (first_xfer < 0) first_xfer = c;
            last_xfer = c;
         end
         holding = cur_val && !ak;
         held    = cur_data;
         @(posedge clk); #1;
      end
      tv = 1'b0; tl = 1'b0;
      beats = bi;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_val", 64'(cur_val), 64'd0);
      check("rst_data", 64'(cur_data), 64'd0);
      check("rst_tready", 64'(cur_tready), 64'd0);
      check("rst_ovs", 64'(cur_ovs), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_tready", 64'(cur_tready), 64'd1);
      @(posedge clk); #1;

      // Cut-through 4-beat packet, ack held high
      sel = 0;
      run(4, 0, 0, 0, 0, 0, 12);
      check("ct4_beats", 64'(beats), 64'd4);
      check("ct4_latency", 64'(first_val), 64'(first_acc + 1));
      check("ct4_b2b", 64'(last_xfer - first_xfer), 64'd3);
      exp_pkt(4, 0, 256);
      cmp_flits("ct4");

      // Two single-beat packets
      run(1, 1, 100, 0, 0, 0, 8);
      exp_pkt(1, 100, 256);
      exp_pkt(1, 101, 256);
      cmp_flits("single");
      check("single_idle", 64'(u_ct.state), 64'(ST_IDLE));

      // 20-beat packet with ack low long enough to fill the FIFO
      run(20, 0, 200, 0, 20, 0, 60);
      check("fill_tready_drop", 64'(first_full), 64'd16);
      check("fill_stable", 64'(stab_err), 64'd0);
      check("fill_beats", 64'(beats), 64'd20);
      exp_pkt(20, 200, 256);
      cmp_flits("fill");

      // 20-beat packet with a 5-cycle ack gap
      run(20, 0, 300, 3, 5, 0, 40);
      check("hold_stable", 64'(stab_err), 64'd0);
      exp_pkt(20, 300, 256);
      cmp_flits("hold");

      // Store-and-forward: 3 beats spread over 11 cycles
      sel = 1;
      run(3, 0, 400, 0, 0, 4, 20);
      check("sf3_last_acc", 64'(last_acc), 64'd10);
      check("sf3_first_val", 64'(first_val), 64'd11);
      check("sf3_b2b", 64'(last_xfer - first_xfer), 64'd2);
      exp_pkt(3, 400, 256);
      cmp_flits("sf3");

      // Store-and-forward: 40-beat packet escapes on a full FIFO
      run(40, 0, 500, 0, 0, 0, 100);
      check("sf40_escape", 64'(first_val), 64'd16);
      check("sf40_beats", 64'(beats), 64'd40);
      exp_pkt(40, 500, 256);
      cmp_flits("sf40");

      // MAX_FLITS=4: 7-beat packet truncated, 2-beat packet follows
      sel = 2;
      run(7, 2, 600, 0, 0, 0, 30);
      check("mf_ovs", 64'(cur_ovs), 64'd1);
      check("mf_beats", 64'(beats), 64'd9);
      exp_pkt(7, 600, 4);
      exp_pkt(2, 607, 4);
      cmp_flits("mf");

      // Reset with 6 beats of an unfinished packet queued
      sel = 0;
      ak  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tv = 1'b1; td = dgen(650 + i); tk = kgen(650 + i); tl = 1'b0;
         @(posedge clk); #1;
      end
      tv = 1'b0;
      #1;
      check("midrst_pre_val", 64'(cur_val), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_tready", 64'(cur_tready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst_val", 64'(cur_val), 64'd0);
      check("midrst_data", 64'(cur_data), 64'd0);
      check("midrst_ovs_mf", 64'(ov[2]), 64'd0);
      @(posedge clk); #1;
      run(2, 0, 700, 0, 0, 0, 8);
      exp_pkt(2, 700, 256);
      cmp_flits("after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
